exe_accel_dispatch: RTL and testbench
=====================================

# exe_accel_dispatch

Execute-stage dispatcher for the NTT, PWAM and Keccak accelerators. It sits directly downstream of the ID/EXE pipeline register and consumes that register's `ID_EXE_ntt_start`, `ID_EXE_pwam_start` and `ID_EXE_keccak_start` pulses. For each start it issues a one-cycle go pulse to the selected engine, holds the pipeline stalled until the engine reports done or a timeout expires, then releases the pipeline with a completion pulse. It also keeps sticky error flags and records a busy-cycle count for the last job.

## Interface

**Parameters**
- `DATA_BITS`, default 64: width of the job argument.
- `TIMEOUT`, default 4096: maximum number of WAIT cycles per job. Legal range is 2 to 65535.

**Ports**
- `clk`  in  1  System clock. All logic is on the rising edge.
- `rst`  in  1  Reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `ID_EXE_ntt_start`  in  1  NTT start request from the ID/EXE register.
- `ID_EXE_pwam_start`  in  1  PWAM start request.
- `ID_EXE_keccak_start`  in  1  Keccak start request.
- `ID_EXE_counter`  in  DATA_BITS  Job argument, captured at accept.
- `ntt_done`  in  1  NTT completion level/pulse.
- `pwam_done`  in  1  PWAM completion.
- `keccak_done`  in  1  Keccak completion.
- `err_clr`  in  1  Clears the sticky error flags.
- `ntt_go`  out  1  One-cycle start pulse to NTT.
- `pwam_go`  out  1  One-cycle start pulse to PWAM.
- `keccak_go`  out  1  One-cycle start pulse to Keccak.
- `accel_arg`  out  DATA_BITS  Job argument latched at accept.
- `accel_sel`  out  2  Latched engine code: 00 none, 01 NTT, 10 PWAM, 11 Keccak.
- `accel_stall`  out  1  Pipeline stall; drives the ID/EXE CE low and freezes IF/ID.
- `accel_busy`  out  1  High whenever state is not IDLE.
- `job_done`  out  1  One-cycle completion pulse.
- `busy_cycles`  out  16  Number of WAIT cycles of the last job.
- `err_multi`  out  1  Sticky: more than one start was seen in the same cycle.
- `err_timeout`  out  1  Sticky: a job hit the timeout.

## Operation

**States**
- IDLE
- ISSUE
- WAIT
- DRAIN

**Reset**
- On any clock edge with `rst`=0, the block enters IDLE, regardless of current state.
- Every registered output resets to 0: `accel_arg`, `accel_sel`, `busy_cycles`, both error flags, all go pulses, `job_done`, and the internal count.
- Engines are not reset by this block. A go pulse pending at reset is never issued.

**IDLE**
- If any start input is 1, the block accepts one request: latches `accel_sel` and `accel_arg <= ID_EXE_counter`, then moves to ISSUE.
- Priority when several starts are high: NTT, then PWAM, then Keccak. Multiple starts also set `err_multi`.
- With no start input high, the block stays in IDLE.

**ISSUE**
- Asserts the selected go output for exactly one cycle.
- Clears the internal count to 0.
- Moves to WAIT.
- Done inputs are ignored in this state.

**WAIT**
- Samples only the selected engine's done input.
- done=1: `busy_cycles <= count+1`, move to DRAIN.
- done=0 and count == TIMEOUT-1: `busy_cycles <= TIMEOUT`, set `err_timeout`, move to DRAIN.
- Otherwise: count increments and the block stays in WAIT.
- If done and the timeout condition occur in the same cycle, done wins and no error is flagged.

**DRAIN**
- `job_done`=1 for this cycle.
- Moves to IDLE.

**Combinational outputs**
- `accel_stall` = (state != IDLE) | (state == IDLE & any start).
- `accel_busy` = (state != IDLE).

**Other rules**
- Start inputs seen in ISSUE, WAIT or DRAIN are ignored.
- Done inputs from unselected engines are ignored.
- `err_clr` clears both error flags. If a set event occurs in the same cycle as `err_clr`, the set wins.
- Count arithmetic is 16-bit unsigned and never wraps, because the timeout bound stops it first.

## Timing

- A start seen in IDLE at cycle T causes `accel_stall`=1 combinationally in cycle T.
- ISSUE occupies T+1, and the go pulse is high during T+1.
- WAIT begins at T+2.
- The first done sampled in WAIT at cycle D gives DRAIN at D+1 with `job_done`=1.
- IDLE is reached at D+2, with `accel_stall`=0 from D+2.
- Minimum occupancy is 4 cycles from start to `accel_stall` low (done in the first WAIT cycle gives `busy_cycles`=1).
- Back-to-back: a new start can be accepted in the D+2 IDLE cycle.
- `accel_sel` and `accel_arg` hold their value until the next accept.

## Test plan

1. Reset, then `ID_EXE_pwam_start`=1 at cycle 0 with `ID_EXE_counter`=0x55, and `pwam_done`=1 at cycle 5 → `accel_stall`=1 from cycle 0 to 6, `pwam_go`=1 only at cycle 1, `accel_sel`=10, `accel_arg`=0x55, `job_done`=1 at cycle 6, `busy_cycles`=4, stall low at cycle 7.
2. NTT and Keccak start together → NTT selected (`accel_sel`=01), `err_multi`=1, `keccak_go` never pulses. Then `err_clr` → `err_multi`=0.
3. TIMEOUT=8, Keccak started, no done → DRAIN after 8 WAIT cycles, `busy_cycles`=8, `err_timeout`=1, `job_done` pulses once.
4. NTT job, `pwam_done` pulsed during WAIT, then `ntt_done` → the PWAM done is ignored and the job completes only on `ntt_done`. `ntt_done` held high during ISSUE is also ignored; the job completes at the first WAIT cycle (`busy_cycles`=1).
5. `rst`=0 asserted for one cycle during WAIT → all outputs 0 on the next edge, state IDLE, no `job_done`. A following start behaves as in scenario 1.
6. New start in the IDLE cycle immediately after DRAIN → accepted, with the go pulse exactly one cycle later. A start presented during WAIT is ignored.

Source files
------------

// File: rtl/exe_accel_dispatch.sv
// ----------------------------------------------------------------------------
// exe_accel_dispatch
//
// Execute-stage dispatcher for the NTT, PWAM and Keccak accelerators. Accepts
// one start request from the ID/EXE register, sends a one-cycle go pulse to the
// chosen engine, stalls the pipeline until that engine's done (or a timeout),
// then releases the pipeline with a one-cycle job_done pulse.
//
// Parameters
//   DATA_BITS : width of the job argument
//   TIMEOUT   : maximum WAIT cycles per job (2..65535)
//
// Ports
//   clk                      : clock, rising edge
//   rst                      : synchronous active-low reset
//   ID_EXE_*_start           : start requests (priority NTT > PWAM > Keccak)
//   ID_EXE_counter           : job argument, captured at accept
//   ntt/pwam/keccak_done     : engine completion inputs
//   err_clr                  : clears sticky error flags
//   ntt/pwam/keccak_go       : one-cycle engine start pulses
//   accel_arg, accel_sel     : latched job argument / engine code
//   accel_stall, accel_busy  : pipeline stall / block busy
//   job_done                 : one-cycle completion pulse
//   busy_cycles              : WAIT cycles taken by the last job
//   err_multi, err_timeout   : sticky error flags
// ----------------------------------------------------------------------------
module exe_accel_dispatch #(
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ID_EXE_ntt_start,
    input  logic                 ID_EXE_pwam_start,
    input  logic                 ID_EXE_keccak_start,
    input  logic [DATA_BITS-1:0] ID_EXE_counter,
    input  logic                 ntt_done,
    input  logic                 pwam_done,
    input  logic                 keccak_done,
    input  logic                 err_clr,
    output logic                 ntt_go,
    output logic                 pwam_go,
    output logic                 keccak_go,
    output logic [DATA_BITS-1:0] accel_arg,
    output logic [1:0]           accel_sel,
    output logic                 accel_stall,
    output logic                 accel_busy,
    output logic                 job_done,
    output logic [15:0]          busy_cycles,
    output logic                 err_multi,
    output logic                 err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] LP_CNT_MAX  = 16'(TIMEOUT);

    localparam logic [1:0] SEL_NTT    = 2'b01;
    localparam logic [1:0] SEL_PWAM   = 2'b10;
    localparam logic [1:0] SEL_KECCAK = 2'b11;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [DATA_BITS-1:0] r_arg,         w_arg_nxt;
    logic [1:0]           r_sel,         w_sel_nxt;
    logic [15:0]          r_busy_cycles, w_busy_cycles_nxt;
    logic [15:0]          r_count,       w_count_nxt;
    logic [2:0]           r_go,          w_go_nxt;       // {ntt, pwam, keccak}
    logic                 r_job_done,    w_job_done_nxt;
    logic                 r_err_multi,   w_err_multi_nxt;
    logic                 r_err_timeout, w_err_timeout_nxt;

    logic                 w_any_start;
    logic                 w_multi_start;
    logic                 w_sel_done;
    logic                 w_set_multi;
    logic                 w_set_timeout;

    assign w_any_start   = ID_EXE_ntt_start | ID_EXE_pwam_start | ID_EXE_keccak_start;
    assign w_multi_start = (ID_EXE_ntt_start  & ID_EXE_pwam_start)   |
                           (ID_EXE_ntt_start  & ID_EXE_keccak_start) |
                           (ID_EXE_pwam_start & ID_EXE_keccak_start);

    // Only the latched engine's done is ever observed.
    always_comb begin
        w_sel_done = 1'b0;
        case (r_sel)
            SEL_NTT:    w_sel_done = ntt_done;
            SEL_PWAM:   w_sel_done = pwam_done;
            SEL_KECCAK: w_sel_done = keccak_done;
            default:    w_sel_done = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_arg_nxt         = r_arg;
        w_sel_nxt         = r_sel;
        w_busy_cycles_nxt = r_busy_cycles;
        w_count_nxt       = r_count;
        w_go_nxt          = 3'b000;
        w_job_done_nxt    = 1'b0;
        w_set_multi       = 1'b0;
        w_set_timeout     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_any_start) begin
                    w_state_nxt = S_ISSUE;
                    w_arg_nxt   = ID_EXE_counter;
                    w_set_multi = w_multi_start;
                    // go is registered here so it is high exactly during ISSUE.
                    if (ID_EXE_ntt_start) begin
                        w_sel_nxt = SEL_NTT;
                        w_go_nxt  = 3'b100;
                    end else if (ID_EXE_pwam_start) begin
                        w_sel_nxt = SEL_PWAM;
                        w_go_nxt  = 3'b010;
                    end else begin
                        w_sel_nxt = SEL_KECCAK;
                        w_go_nxt  = 3'b001;
                    end
                end
            end
            S_ISSUE: begin
                w_count_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // done takes precedence over the timeout in the same cycle.
                if (w_sel_done) begin
                    w_busy_cycles_nxt = r_count + 16'd1;
                    w_job_done_nxt    = 1'b1;
                    w_state_nxt       = S_DRAIN;
                end else if (r_count == LP_CNT_LAST) begin
                    w_busy_cycles_nxt = LP_CNT_MAX;
                    w_set_timeout     = 1'b1;
                    w_job_done_nxt    = 1'b1;
                    w_state_nxt       = S_DRAIN;
                end else begin
                    w_count_nxt = r_count + 16'd1;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A set event in the same cycle as err_clr wins.
        w_err_multi_nxt   = w_set_multi   | (r_err_multi   & ~err_clr);
        w_err_timeout_nxt = w_set_timeout | (r_err_timeout & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_arg         <= '0;
            r_sel         <= '0;
            r_busy_cycles <= '0;
            r_count       <= '0;
            r_go          <= '0;
            r_job_done    <= 1'b0;
            r_err_multi   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_arg         <= w_arg_nxt;
            r_sel         <= w_sel_nxt;
            r_busy_cycles <= w_busy_cycles_nxt;
            r_count       <= w_count_nxt;
            r_go          <= w_go_nxt;
            r_job_done    <= w_job_done_nxt;
            r_err_multi   <= w_err_multi_nxt;
            r_err_timeout <= w_err_timeout_nxt;
        end
    end

    assign ntt_go      = r_go[2];
    assign pwam_go     = r_go[1];
    assign keccak_go   = r_go[0];
    assign accel_arg   = r_arg;
    assign accel_sel   = r_sel;
    assign accel_busy  = (r_state != S_IDLE);
    assign accel_stall = (r_state != S_IDLE) | w_any_start;
    assign job_done    = r_job_done;
    assign busy_cycles = r_busy_cycles;
    assign err_multi   = r_err_multi;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_exe_accel_dispatch.sv
// ----------------------------------------------------------------------------
// tb_exe_accel_dispatch
//
// Directed bench for exe_accel_dispatch with TIMEOUT=8. Inputs for cycle N are
// driven 2 time units after rising edge N; outputs are checked 1 unit later.
// ----------------------------------------------------------------------------
module tb_exe_accel_dispatch;

    logic        clk;
    logic        rst;
    logic        ID_EXE_ntt_start;
    logic        ID_EXE_pwam_start;
    logic        ID_EXE_keccak_start;
    logic [63:0] ID_EXE_counter;
    logic        ntt_done;
    logic        pwam_done;
    logic        keccak_done;
    logic        err_clr;
    logic        ntt_go;
    logic        pwam_go;
    logic        keccak_go;
    logic [63:0] accel_arg;
    logic [1:0]  accel_sel;
    logic        accel_stall;
    logic        accel_busy;
    logic        job_done;
    logic [15:0] busy_cycles;
    logic        err_multi;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    exe_accel_dispatch #(
        .DATA_BITS (64),
        .TIMEOUT   (8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ID_EXE_ntt_start    (ID_EXE_ntt_start),
        .ID_EXE_pwam_start   (ID_EXE_pwam_start),
        .ID_EXE_keccak_start (ID_EXE_keccak_start),
        .ID_EXE_counter      (ID_EXE_counter),
        .ntt_done            (ntt_done),
        .pwam_done           (pwam_done),
        .keccak_done         (keccak_done),
        .err_clr             (err_clr),
        .ntt_go              (ntt_go),
        .pwam_go             (pwam_go),
        .keccak_go           (keccak_go),
        .accel_arg           (accel_arg),
        .accel_sel           (accel_sel),
        .accel_stall         (accel_stall),
        .accel_busy          (accel_busy),
        .job_done            (job_done),
        .busy_cycles         (busy_cycles),
        .err_multi           (err_multi),
        .err_timeout         (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scenario 1: PWAM job, arg 0x55, done at cycle 5 -> busy_cycles 4.
    task automatic pwam_job_55();
        ID_EXE_pwam_start = 1'b1; ID_EXE_counter = 64'h55; #1;       // cycle 0
        chk("s1_stall_c0", accel_stall, 1);
        chk("s1_busy_c0", accel_busy, 0);
        tick(); ID_EXE_pwam_start = 1'b0; ID_EXE_counter = 64'h0; #1; // cycle 1
        chk("s1_pwam_go_c1", pwam_go, 1);
        chk("s1_ntt_go_c1", ntt_go, 0);
        chk("s1_sel", accel_sel, 2'b10);
        chk("s1_arg", accel_arg, 64'h55);
        chk("s1_stall_c1", accel_stall, 1);
        tick(); #1;                                                   // cycle 2
        chk("s1_pwam_go_c2", pwam_go, 0);
        chk("s1_stall_c2", accel_stall, 1);
        tick(); tick(); #1;                                           // cycle 4
        chk("s1_stall_c4", accel_stall, 1);
        tick(); pwam_done = 1'b1; #1;                                 // cycle 5
        chk("s1_jd_c5", job_done, 0);
        tick(); pwam_done = 1'b0; #1;                                 // cycle 6
        chk("s1_job_done_c6", job_done, 1);
        chk("s1_busy_cycles", busy_cycles, 16'd4);
        chk("s1_stall_c6", accel_stall, 1);
        tick(); #1;                                                   // cycle 7
        chk("s1_stall_c7", accel_stall, 0);
        chk("s1_jd_c7", job_done, 0);
        chk("s1_busy_c7", accel_busy, 0);
        chk("s1_arg_hold", accel_arg, 64'h55);
    endtask

    initial begin
        int pulses;
        rst = 1'b0;
        ID_EXE_ntt_start = 1'b0; ID_EXE_pwam_start = 1'b0; ID_EXE_keccak_start = 1'b0;
        ID_EXE_counter = 64'h0;
        ntt_done = 1'b0; pwam_done = 1'b0; keccak_done = 1'b0; err_clr = 1'b0;
        tick(); tick();
        rst = 1'b1; #1;
        chk("rst_sel", accel_sel, 0);
        chk("rst_arg", accel_arg, 0);
        chk("rst_busy_cycles", busy_cycles, 0);
        chk("rst_stall", accel_stall, 0);
        chk("rst_busy", accel_busy, 0);
        chk("rst_job_done", job_done, 0);
        chk("rst_err_multi", err_multi, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_go", {ntt_go, pwam_go, keccak_go}, 3'b000);
        tick();

        // Scenario 1
        pwam_job_55();

        // Scenario 2: NTT + Keccak together
        ID_EXE_ntt_start = 1'b1; ID_EXE_keccak_start = 1'b1; ID_EXE_counter = 64'h9; #1;
        chk("s2_stall_c0", accel_stall, 1);
        tick(); ID_EXE_ntt_start = 1'b0; ID_EXE_keccak_start = 1'b0; #1;   // ISSUE
        chk("s2_ntt_go", ntt_go, 1);
        chk("s2_keccak_go_c1", keccak_go, 0);
        chk("s2_sel", accel_sel, 2'b01);
        chk("s2_err_multi", err_multi, 1);
        tick(); ntt_done = 1'b1; #1;                                        // WAIT 0
        chk("s2_keccak_go_c2", keccak_go, 0);
        tick(); ntt_done = 1'b0; #1;                                        // DRAIN
        chk("s2_job_done", job_done, 1);
        chk("s2_busy_cycles", busy_cycles, 16'd1);
        tick(); err_clr = 1'b1; #1;                                         // IDLE
        chk("s2_err_multi_held", err_multi, 1);
        tick(); err_clr = 1'b0; #1;
        chk("s2_err_multi_clr", err_multi, 0);
        chk("s2_err_timeout", err_timeout, 0);

        // Scenario 3: Keccak timeout (TIMEOUT=8)
        ID_EXE_keccak_start = 1'b1; ID_EXE_counter = 64'h3; #1;             // cycle 0
        tick(); ID_EXE_keccak_start = 1'b0; #1;                             // cycle 1
        chk("s3_keccak_go", keccak_go, 1);
        chk("s3_sel", accel_sel, 2'b11);
        pulses = 0;
        for (int i = 2; i <= 11; i++) begin
            tick(); #1;
            if (job_done === 1'b1) pulses++;
            if (i == 9) chk("s3_jd_c9", job_done, 0);
            if (i == 10) begin
                chk("s3_jd_c10", job_done, 1);
                chk("s3_busy_cycles", busy_cycles, 16'd8);
                chk("s3_err_timeout", err_timeout, 1);
            end
            if (i == 11) chk("s3_stall_c11", accel_stall, 0);
        end
        chk("s3_job_done_pulses", pulses, 1);

        // Scenario 4a: ntt_done high during ISSUE is ignored
        ID_EXE_ntt_start = 1'b1; ID_EXE_counter = 64'h21; #1;               // cycle 0
        tick(); ID_EXE_ntt_start = 1'b0; ntt_done = 1'b1; #1;               // ISSUE
        tick(); #1;                                                         // WAIT 0
        chk("s4a_jd_c2", job_done, 0);
        tick(); ntt_done = 1'b0; #1;                                        // DRAIN
        chk("s4a_jd_c3", job_done, 1);
        chk("s4a_busy_cycles", busy_cycles, 16'd1);
        tick(); #1;

        // Scenario 4b: pwam_done during an NTT job is ignored
        ID_EXE_ntt_start = 1'b1; ID_EXE_counter = 64'h22; #1;               // cycle 0
        tick(); ID_EXE_ntt_start = 1'b0; #1;                                // ISSUE
        tick(); pwam_done = 1'b1; #1;                                       // WAIT c=0
        tick(); pwam_done = 1'b0; #1;                                       // WAIT c=1
        chk("s4b_jd_c3", job_done, 0);
        chk("s4b_stall_c3", accel_stall, 1);
        tick(); ntt_done = 1'b1; #1;                                        // WAIT c=2
        tick(); ntt_done = 1'b0; #1;                                        // DRAIN
        chk("s4b_jd_c5", job_done, 1);
        chk("s4b_busy_cycles", busy_cycles, 16'd3);

        // Scenario 6: back-to-back accept, start during WAIT ignored
        tick(); ID_EXE_pwam_start = 1'b1; ID_EXE_counter = 64'hAB; #1;      // IDLE c6
        chk("s6_stall_accept", accel_stall, 1);
        tick(); ID_EXE_pwam_start = 1'b0; #1;                               // ISSUE c7
        chk("s6_pwam_go", pwam_go, 1);
        chk("s6_arg", accel_arg, 64'hAB);
        tick(); ID_EXE_keccak_start = 1'b1; ID_EXE_counter = 64'h11; #1;    // WAIT c8
        tick(); ID_EXE_keccak_start = 1'b0; pwam_done = 1'b1; #1;           // WAIT c9
        chk("s6_keccak_go", keccak_go, 0);
        chk("s6_sel_hold", accel_sel, 2'b10);
        chk("s6_arg_hold", accel_arg, 64'hAB);
        tick(); pwam_done = 1'b0; #1;                                       // DRAIN
        chk("s6_busy_cycles", busy_cycles, 16'd2);
        chk("s6_jd", job_done, 1);
        tick(); #1;
        chk("s6_idle_stall", accel_stall, 0);

        // Scenario 5: reset during WAIT
        ID_EXE_ntt_start = 1'b1; ID_EXE_counter = 64'h77; #1;               // cycle 0
        tick(); ID_EXE_ntt_start = 1'b0; #1;                                // ISSUE
        tick(); #1;                                                         // WAIT
        tick(); rst = 1'b0; ntt_done = 1'b1; #1;                            // WAIT, rst
        tick(); rst = 1'b1; #1;
        chk("s5_sel", accel_sel, 0);
        chk("s5_arg", accel_arg, 0);
        chk("s5_busy_cycles", busy_cycles, 0);
        chk("s5_stall", accel_stall, 0);
        chk("s5_busy", accel_busy, 0);
        chk("s5_job_done", job_done, 0);
        chk("s5_err_timeout", err_timeout, 0);
        chk("s5_go", {ntt_go, pwam_go, keccak_go}, 3'b000);
        tick(); ntt_done = 1'b0; #1;
        chk("s5_job_done_after", job_done, 0);
        chk("s5_busy_after", accel_busy, 0);

        // Reset in the accept cycle: no go pulse ever issued
        ID_EXE_pwam_start = 1'b1; ID_EXE_counter = 64'h5A; rst = 1'b0; #1;
        tick(); ID_EXE_pwam_start = 1'b0; rst = 1'b1; #1;
        chk("rst_accept_go", pwam_go, 0);
        chk("rst_accept_busy", accel_busy, 0);
        tick();

        // Scenario 5 follow-up: a fresh job behaves as scenario 1
        pwam_job_55();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
